dmem_arbiter: RTL and testbench

Sequences and shares the 256×16 data memory between two requesters: port 0 (core load/store) and port 1 (debug/DMA). Grants are round-robin, and each access is one memory cycle. The block also issues the memory's dump strobe (`print_en`) on request, and only when no access is in flight. It sits between the requesters and `data_memory` and is the sole driver of every memory input.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 38 +++
 rtl/rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and sizes for the data-memory arbiter slice
package dmem_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DUMP = 2'd2
  } dmem_arb_state_t;

  typedef logic port_id_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester, dump and memory-side signals of the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              dump_req;
  logic              dump_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              print_en;

  // master: the requesters plus the memory; slave: the arbiter itself
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dump_req, mem_rd_data,
    input  ack0, ack1, rdata0, rdata1, dump_done, mem_addr, mem_wr_en, mem_wr_data, print_en
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dump_req, mem_rd_data,
    output ack0, ack1, rdata0, rdata1, dump_done, mem_addr, mem_wr_en, mem_wr_data, print_en
  );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin picker
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] eligible,
  input  port_id_t   last_gnt,
  output logic       gnt_valid,
  output port_id_t   gnt_id
);

  always_comb begin
    gnt_valid = |eligible;
    gnt_id    = 1'b0;
    case (eligible)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_gnt;
      default: gnt_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sharing of the data memory between two ports,
// with registered memory inputs and a dump strobe issued only between accesses
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  import dmem_pkg::*;

  dmem_arb_state_t   state;
  port_id_t          last_gnt;
  port_id_t          gnt_id_q;
  logic              dump_pend;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;
  logic              mem_wr_en_q;
  logic              print_en_q;
  logic              dump_done_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic [1:0] eligible;
  logic       gnt_valid;
  port_id_t   win;

  // A requester still holding req during its ack cycle must not win again
  assign eligible = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

  rr_arb2 u_rr_arb2 (
    .eligible  (eligible),
    .last_gnt  (last_gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_gnt      <= 1'b1;
      gnt_id_q      <= 1'b0;
      dump_pend     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      mem_wr_en_q   <= 1'b0;
      print_en_q    <= 1'b0;
      dump_done_q   <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      dump_done_q <= 1'b0;
      print_en_q  <= 1'b0;
      if (bus.dump_req) begin
        dump_pend <= 1'b1;
      end
      case (state)
        IDLE: begin
          // A dump request seen this edge is served at once; later ones merge into dump_pend
          if (dump_pend || bus.dump_req) begin
            dump_pend  <= 1'b0;
            print_en_q <= 1'b1;
            state      <= DUMP;
          end else if (gnt_valid) begin
            gnt_id_q      <= win;
            last_gnt      <= win;
            mem_addr_q    <= win ? bus.addr1  : bus.addr0;
            mem_wr_data_q <= win ? bus.wdata1 : bus.wdata0;
            mem_wr_en_q   <= win ? bus.we1    : bus.we0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (gnt_id_q) begin
            rdata1_q <= bus.mem_rd_data;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= bus.mem_rd_data;
            ack0_q   <= 1'b1;
          end
          mem_wr_en_q <= 1'b0;
          state       <= IDLE;
        end
        DUMP: begin
          dump_done_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.print_en    = print_en_q;
  assign bus.dump_done   = dump_done_q;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a write-through memory model
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory with level-sensitive write and combinational, write-through read
  logic [15:0] mem [256];
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
  assign bus.mem_rd_data = bus.mem_wr_en ? bus.mem_wr_data : mem[bus.mem_addr];

  logic [15:0] shadow [256];
  bit   [255:0] valid = '0;

  typedef struct {
    bit          port;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_wen;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_access(input bit p, input bit we, input logic [7:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat, output int wen);
    lat = 0;
    wen = 0;
    rd  = '0;
    if (!p) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.mem_wr_en) wen++;
      if (p ? bus.ack1 : bus.ack0) begin
        rd = p ? bus.rdata1 : bus.rdata0;
        break;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;
    int lat, wen, n0, n1, acks;
    int order [$];
    logic [15:0] pv, dv;
    bit busy [2];
    bit r_we [2];
    logic [7:0] r_addr [2];
    logic [15:0] r_wdata [2];
    int r_wait [2];
    bit pexp;

    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
    bus.dump_req = 0;

    vecs[0] = '{0, 1, 8'h12, 16'hBEEF, 16'hBEEF, 1};
    vecs[1] = '{0, 0, 8'h12, 16'h0000, 16'hBEEF, 0};
    vecs[2] = '{0, 1, 8'hFF, 16'h1234, 16'h1234, 1};
    vecs[3] = '{1, 1, 8'h00, 16'h5678, 16'h5678, 1};
    vecs[4] = '{0, 0, 8'hFF, 16'h0000, 16'h1234, 0};
    vecs[5] = '{1, 0, 8'h00, 16'h0000, 16'h5678, 0};
    vecs[6] = '{1, 0, 8'h12, 16'h0000, 16'hBEEF, 0};
    vecs[7] = '{1, 1, 8'h12, 16'h0A0A, 16'h0A0A, 1};
    vecs[8] = '{0, 0, 8'h12, 16'h0000, 16'h0A0A, 0};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ack0", bus.ack0, 0);
    check("rst_ack1", bus.ack1, 0);
    check("rst_rdata0", bus.rdata0, 0);
    check("rst_rdata1", bus.rdata1, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_mem_wr_data", bus.mem_wr_data, 0);
    check("rst_print_en", bus.print_en, 0);
    check("rst_dump_done", bus.dump_done, 0);

    // Contention from reset: port 0 favoured first, then strict alternation
    bus.req0 = 1; bus.addr0 = 8'h01;
    bus.req1 = 1; bus.addr1 = 8'h02;
    n0 = 0; n1 = 0;
    for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) check("cont_dual_ack", 1, 0);
      if (bus.ack0) begin order.push_back(0); n0++; if (n0 == 4) bus.req0 = 0; end
      if (bus.ack1) begin order.push_back(1); n1++; if (n1 == 4) bus.req1 = 0; end
    end
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    check("cont_acks0", n0, 4);
    check("cont_acks1", n1, 4);
    check("cont_len", order.size(), 8);
    for (int i = 0; i < order.size() && i < 8; i++) check($sformatf("cont_order[%0d]", i), order[i], i % 2);

    // Table of single-port accesses
    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat, wen);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_wr_en_cycles", i), wen, vecs[i].exp_wen);
      if (vecs[i].we) begin
        shadow[vecs[i].addr] = vecs[i].wdata;
        valid[vecs[i].addr] = 1'b1;
      end
    end

    // Held req on port 1: masked during the ack cycle, regranted on the edge after
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 8'h12;
    acks = 0; pv = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (bus.ack1) begin acks++; pv[c] = 1'b1; end
    end
    bus.req1 = 0;
    @(negedge clk);
    check("held_ack_cycles", pv, 16'h0024);
    check("held_ack_count", acks, 2);

    // Dump and req0 in the same cycle: dump first, access delayed by 2 cycles
    bus.dump_req = 1; bus.req0 = 1; bus.we0 = 0; bus.addr0 = 8'h12;
    pv = '0; dv = '0; lat = 0; rd = '0;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      bus.dump_req = 0;
      if (bus.print_en) pv[c] = 1'b1;
      if (bus.dump_done) dv[c] = 1'b1;
      if (bus.ack0 && lat == 0) begin lat = c; rd = bus.rdata0; bus.req0 = 0; end
    end
    check("dumpA_print", pv, 16'h0002);
    check("dumpA_done", dv, 16'h0004);
    check("dumpA_ack_lat", lat, 4);
    check("dumpA_rdata", rd, 16'h0A0A);

    // Second dump_req during DUMP gives exactly one more dump
    bus.dump_req = 1;
    pv = '0; dv = '0;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (bus.print_en) pv[c] = 1'b1;
      if (bus.dump_done) dv[c] = 1'b1;
      bus.dump_req = (c == 1);
    end
    check("dumpB_print", pv, 16'h000A);
    check("dumpB_done", dv, 16'h0014);

    // Reset in the middle of a port 0 write
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 8'h40; bus.wdata0 = 16'hDEAD;
    @(negedge clk);
    check("rmb_wr_en_busy", bus.mem_wr_en, 1);
    check("rmb_addr_busy", bus.mem_addr, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    check("rmb_mem_wr_en", bus.mem_wr_en, 0);
    check("rmb_mem_addr", bus.mem_addr, 0);
    check("rmb_mem_wr_data", bus.mem_wr_data, 0);
    check("rmb_ack0", bus.ack0, 0);
    check("rmb_rdata0", bus.rdata0, 0);
    check("rmb_rdata1", bus.rdata1, 0);
    check("rmb_print_en", bus.print_en, 0);
    check("rmb_dump_done", bus.dump_done, 0);
    bus.req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ack0) acks++;
    end
    check("rmb_no_ack0", acks, 0);
    do_access(1, 0, 8'h40, 16'h0, rd, lat, wen);
    check("rmb_reread_lat", lat, 2);
    check("rmb_reread_wen", wen, 0);
    valid[8'h40] = 1'b0;

    // Randomized traffic against a transaction-level scoreboard
    busy[0] = 0; busy[1] = 0; r_wait[0] = 0; r_wait[1] = 0; pexp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("rnd_dual_ack", bus.ack0 & bus.ack1, 0);
      check("rnd_print_vs_wr", bus.print_en & bus.mem_wr_en, 0);
      if (pexp) check("rnd_done_after_print", bus.dump_done, 1);
      pexp = bus.print_en;
      for (int p = 0; p < 2; p++) begin
        logic a;
        logic [15:0] r;
        a = p ? bus.ack1 : bus.ack0;
        r = p ? bus.rdata1 : bus.rdata0;
        if (a) begin
          if (!busy[p]) begin
            check($sformatf("rnd_spurious_ack%0d", p), 1, 0);
          end else begin
            if (r_we[p]) begin
              check("rnd_wr_rdata", r, r_wdata[p]);
              shadow[r_addr[p]] = r_wdata[p];
              valid[r_addr[p]] = 1'b1;
            end else if (valid[r_addr[p]]) begin
              check("rnd_rd_rdata", r, shadow[r_addr[p]]);
            end
            busy[p] = 0;
          end
        end else if (busy[p]) begin
          r_wait[p]++;
          if (r_wait[p] > 16) begin
            check($sformatf("rnd_timeout%0d", p), 1, 0);
            busy[p] = 0;
          end
        end
        if (!busy[p] && $urandom_range(0, 2) == 0) begin
          busy[p] = 1;
          r_wait[p] = 0;
          r_we[p] = 1'($urandom_range(0, 1));
          r_addr[p] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
          r_wdata[p] = 16'($urandom);
        end
        if (p == 0) begin
          bus.req0 = busy[0]; bus.we0 = r_we[0]; bus.addr0 = r_addr[0]; bus.wdata0 = r_wdata[0];
        end else begin
          bus.req1 = busy[1]; bus.we1 = r_we[1]; bus.addr1 = r_addr[1]; bus.wdata1 = r_wdata[1];
        end
      end
      bus.dump_req = ($urandom_range(0, 15) == 0);
    end
    bus.req0 = 0; bus.req1 = 0; bus.dump_req = 0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
